// File: rtl/thor2022_bus_pkg.sv
// Shared types and constants for the Thor2022 bus master.
package Thor2022_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/thor2022_bus_master.sv
// Single-outstanding bus master: takes one command, runs one bus cycle with a
// timeout, then presents the response until the consumer takes it.
module thor2022_bus_master
  import Thor2022_bus_pkg::*;
#(
  parameter int AWID    = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            rst_i,
  input  logic            clk_i,
  // command side
  input  logic            req_i,
  input  logic            req_we_i,
  input  logic [7:0]      req_sel_i,
  input  logic [AWID-1:0] req_adr_i,
  input  logic [63:0]     req_dat_i,
  output logic            req_rdy_o,
  // response side
  output logic            resp_vld_o,
  input  logic            resp_rdy_i,
  output logic [63:0]     resp_dat_o,
  output logic            resp_err_o,
  // bus side
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [7:0]      sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [63:0]     dat_o,
  input  logic            ack_i,
  input  logic [63:0]     dat_i
);

  // Wide enough to hold TIMEOUT itself, so the counter never wraps.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [7:0]      sel_q, sel_d;
  logic [AWID-1:0] adr_q, adr_d;
  logic [63:0]     dat_q, dat_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [63:0]     rdat_q, rdat_d;
  logic            err_q, err_d;

  // Bus strobes follow the ACCESS state directly, so an async reset drops them at once.
  assign cyc_o      = (state_q == ACCESS);
  assign stb_o      = (state_q == ACCESS);
  assign we_o       = we_q;
  assign sel_o      = sel_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign resp_vld_o = (state_q == RESP);
  assign resp_dat_o = rdat_q;
  assign resp_err_o = err_q;
  // Not ready while reset is held, even though the state already reads IDLE.
  assign req_rdy_o  = (state_q == IDLE) & ~rst_i;

  // Next-state and datapath updates; everything holds unless a transition says otherwise.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tmr_d   = tmr_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = req_we_i;
          sel_d   = req_sel_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
          tmr_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Ack is checked first so it beats a simultaneous timeout.
        if (ack_i) begin
          rdat_d  = we_q ? 64'd0 : dat_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmr_q == TMR_LAST) begin
          rdat_d  = 64'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      tmr_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tmr_q   <= tmr_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_thor2022_bus_master.sv
// Directed plus randomized bench for thor2022_bus_master with a delay-programmable responder.
module tb_thor2022_bus_master;

  localparam int AWID  = 32;
  localparam int TMO   = 8;
  localparam int NEVER = 1000;

  logic            rst_i, clk_i;
  logic            req_i, req_we_i, req_rdy_o;
  logic [7:0]      req_sel_i;
  logic [AWID-1:0] req_adr_i;
  logic [63:0]     req_dat_i;
  logic            resp_vld_o, resp_rdy_i, resp_err_o;
  logic [63:0]     resp_dat_o;
  logic            cyc_o, stb_o, we_o;
  logic [7:0]      sel_o;
  logic [AWID-1:0] adr_o;
  logic [63:0]     dat_o;
  logic            ack_i;
  logic [63:0]     dat_i;

  int checks = 0;
  int errors = 0;

  // responder: acks after ack_dly cycles of cyc_o; stray_ack injects ack outside a cycle
  int   ack_dly = 0;
  int   cyc_cnt = 0;
  logic stray_ack = 1'b0;

  thor2022_bus_master #(.AWID(AWID), .TIMEOUT(TMO)) dut (
    .rst_i(rst_i), .clk_i(clk_i),
    .req_i(req_i), .req_we_i(req_we_i), .req_sel_i(req_sel_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_rdy_o(req_rdy_o),
    .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i),
    .resp_dat_o(resp_dat_o), .resp_err_o(resp_err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_cnt <= cyc_o ? cyc_cnt + 1 : 0;
  assign ack_i = stray_ack | (cyc_o && (cyc_cnt == ack_dly));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // One transaction. Expected outcome comes from the delay alone:
  // acked if dly < TMO (cyc width dly+1), else timeout after TMO cycles.
  task automatic txn(input logic we, input logic [7:0] sel, input logic [AWID-1:0] adr,
                     input logic [63:0] wdat, input logic [63:0] rdat, input int dly,
                     input int hold, input logic stray_in_hold);
    int   lat, ncyc, exp_w;
    logic exp_err;
    logic [63:0] exp_dat;
    exp_err = (dly >= TMO);
    exp_w   = exp_err ? TMO : dly + 1;
    exp_dat = (exp_err || we) ? 64'd0 : rdat;
    ack_dly = dly;
    dat_i   = rdat;
    chk("rdy_idle", {63'd0, req_rdy_o}, 64'd1);
    req_i = 1'b1; req_we_i = we; req_sel_i = sel; req_adr_i = adr; req_dat_i = wdat;
    step();
    req_i = 1'b0; req_dat_i = $urandom; req_adr_i = $urandom;
    lat = 1; ncyc = 0;
    while (!resp_vld_o && lat < 100) begin
      if (cyc_o) begin
        ncyc++;
        chk("bus_adr", {32'd0, adr_o}, {32'd0, adr});
        chk("bus_dat", dat_o, wdat);
        chk("bus_ctl", {54'd0, stb_o, we_o, sel_o}, {54'd0, 1'b1, we, sel});
        chk("rdy_busy", {63'd0, req_rdy_o}, 64'd0);
      end
      step();
      lat++;
    end
    chk("resp_vld", {63'd0, resp_vld_o}, 64'd1);
    chk("latency", 64'(lat), 64'(exp_w + 1));
    chk("cyc_width", 64'(ncyc), 64'(exp_w));
    chk("resp_err", {63'd0, resp_err_o}, {63'd0, exp_err});
    chk("resp_dat", resp_dat_o, exp_dat);
    stray_ack = stray_in_hold;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_vld", {63'd0, resp_vld_o}, 64'd1);
      chk("hold_dat", resp_dat_o, exp_dat);
      chk("hold_err", {63'd0, resp_err_o}, {63'd0, exp_err});
      chk("hold_rdy", {62'd0, req_rdy_o, cyc_o}, 64'd0);
    end
    stray_ack = 1'b0;
    resp_rdy_i = 1'b1;
    step();
    resp_rdy_i = 1'b0;
    chk("post_vld", {63'd0, resp_vld_o}, 64'd0);
    chk("post_idle", {62'd0, req_rdy_o, cyc_o}, 64'd2);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_sel_i = '0; req_adr_i = '0;
    req_dat_i = '0; resp_rdy_i = 1'b0; dat_i = '0;
    repeat (3) step();
    chk("rst_bus", {cyc_o, stb_o, we_o, sel_o, resp_vld_o, resp_err_o, req_rdy_o}, 64'd0);
    chk("rst_adr", {32'd0, adr_o}, 64'd0);
    chk("rst_dat", dat_o | resp_dat_o, 64'd0);
    rst_i = 1'b0;
    step();

    // stray ack in IDLE must not start anything
    stray_ack = 1'b1;
    repeat (2) step();
    stray_ack = 1'b0;
    chk("stray_idle", {61'd0, cyc_o, resp_vld_o, req_rdy_o}, 64'd1);

    txn(1'b1, 8'hFF, 32'h018, 64'h86, 64'hDEAD, 0, 0, 1'b0);          // zero-wait write
    txn(1'b0, 8'hFF, 32'h000, 64'h0, 64'h1234, 1, 0, 1'b0);           // registered-ack read
    txn(1'b0, 8'h0F, 32'h100, 64'h0, 64'h5555, NEVER, 1, 1'b0);       // timeout
    txn(1'b0, 8'hF0, 32'h108, 64'h0, 64'hBEEF, TMO - 1, 0, 1'b0);     // ack on last cycle
    txn(1'b1, 8'h03, 32'h200, 64'h77, 64'h9, 2, 5, 1'b1);             // held response
    txn(1'b0, 8'h0C, 32'h208, 64'h0, 64'hCAFE, 0, 5, 1'b0);           // back-to-back

    // reset mid-ACCESS
    ack_dly = NEVER;
    req_i = 1'b1; req_we_i = 1'b0; req_sel_i = 8'hFF; req_adr_i = 32'h300;
    step();
    req_i = 1'b0;
    repeat (2) step();
    chk("pre_rst_cyc", {63'd0, cyc_o}, 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_cyc", {61'd0, cyc_o, stb_o, resp_vld_o}, 64'd0);
    chk("rst_rdy", {63'd0, req_rdy_o}, 64'd0);
    step();
    #3 rst_i = 1'b0;
    step();
    chk("after_rst", {62'd0, req_rdy_o, resp_vld_o}, 64'd2);
    txn(1'b0, 8'hFF, 32'h308, 64'h0, 64'h4321, 1, 0, 1'b0);

    // randomized transactions
    for (int n = 0; n < 24; n++) begin
      int d;
      case ($urandom_range(0, 4))
        0: d = 0;
        1: d = TMO - 1;
        2: d = NEVER;
        default: d = $urandom_range(0, TMO - 1);
      endcase
      txn(1'($urandom), 8'($urandom), $urandom, {$urandom, $urandom}, {$urandom, $urandom},
          d, $urandom_range(0, 4), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
